// File: rtl/pipe_mux_reg_pkg.sv
// Shared constants for the registered select mux: legal pipeline depths,
// default lane width and the select-error encoding seen by the hazard unit.
package pipe_mux_reg_pkg;

  // Legal register depth range for pipe_mux_reg.
  localparam int PIPE_STAGES_MIN = 1;
  localparam int PIPE_STAGES_MAX = 2;

  // Default lane width for the integer datapath.
  localparam int DEFAULT_WIDTH = 32;

  // Select-error encoding, shared with the hazard unit.
  localparam logic SEL_ERR_FLAG = 1'b1;
  localparam logic SEL_OK_FLAG  = 1'b0;

  // Upstream view of one stage: what the previous stage (or the mux) offers.
  typedef struct packed {
    logic vld;
    logic err;
  } stage_ctrl_t;

  // True when a requested register depth is supported.
  function automatic bit pipe_stages_ok(input int stages);
    return (stages >= PIPE_STAGES_MIN) && (stages <= PIPE_STAGES_MAX);
  endfunction

endpackage

// File: rtl/pipe_mux_reg_mux.sv
// Combinational N-to-1 lane select. A select index past the last lane
// yields zero data and raises the error flag instead of aliasing a lane.
module mux_nto1
  import pipe_mux_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] lanes,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   data,
  output logic               err
);

  // Scan every lane; only an in-range index clears the error flag.
  always_comb begin
    data = '0;
    err  = SEL_ERR_FLAG;
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        data = lanes[k*WIDTH +: WIDTH];
        err  = SEL_OK_FLAG;
      end
    end
  end

endmodule

// File: rtl/pipe_mux_reg.sv
// Registered N-way select for pipeline stage boundaries. One mux feeds a
// chain of 1 or 2 register stages that share a global stall (freeze the
// whole chain) and flush (invalidate every stage). Outputs come straight
// from the last stage; the error flag is qualified by valid.
module pipe_mux_reg
  import pipe_mux_reg_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter int               N           = 4,
  parameter int               PIPE_STAGES = 1,
  parameter logic [WIDTH-1:0] RST_VAL     = '0,
  localparam int              SEL_W       = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic               out_sel_err
);

  // Only the supported depths elaborate.
  if (!pipe_stages_ok(PIPE_STAGES)) begin : g_bad_stages
    $error("pipe_mux_reg: PIPE_STAGES must be 1 or 2");
  end

  // Chain index 0 is the mux result; index s+1 is the output of stage s.
  stage_ctrl_t [PIPE_STAGES:0]            chain_ctrl;
  logic        [PIPE_STAGES:0][WIDTH-1:0] chain_data;

  logic [WIDTH-1:0] mux_data;
  logic             mux_err;

  mux_nto1 #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_mux (
    .lanes (in_data),
    .sel   (in_sel),
    .data  (mux_data),
    .err   (mux_err)
  );

  // Select result enters the chain qualified by the input valid.
  assign chain_ctrl[0].vld = in_valid;
  assign chain_ctrl[0].err = mux_err;
  assign chain_data[0]     = mux_data;

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    logic             vld_q;
    logic             err_q;
    logic [WIDTH-1:0] data_q;

    // Stage boundary: flush beats stall beats advance. Data and error only
    // load behind a valid upstream so idle cycles leave the register quiet.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q  <= 1'b0;
        err_q  <= 1'b0;
        data_q <= RST_VAL;
      end else if (flush) begin
        vld_q  <= 1'b0;
        err_q  <= 1'b0;
        data_q <= RST_VAL;
      end else if (!stall) begin
        vld_q <= chain_ctrl[s].vld;
        if (chain_ctrl[s].vld) begin
          err_q  <= chain_ctrl[s].err;
          data_q <= chain_data[s];
        end
      end
    end

    assign chain_ctrl[s+1].vld = vld_q;
    assign chain_ctrl[s+1].err = err_q;
    assign chain_data[s+1]     = data_q;
  end

  // Output boundary: last stage drives the ports; error never shows on an
  // invalid slot.
  assign out_valid   = chain_ctrl[PIPE_STAGES].vld;
  assign out_data    = chain_data[PIPE_STAGES];
  assign out_sel_err = chain_ctrl[PIPE_STAGES].err & chain_ctrl[PIPE_STAGES].vld;

endmodule

// File: tb/tb_pipe_mux_reg.sv
// Bench for pipe_mux_reg: three instances (N=4/1 stage, N=3/1 stage,
// N=5/2 stages with non-zero reset value) share clock and control, and are
// compared each cycle against a slot-based reference model.
module tb_pipe_mux_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, stall, flush;

  logic [31:0] lane_a [4];
  logic [31:0] lane_b [3];
  logic [15:0] lane_c [5];
  logic [1:0]  sel_a, sel_b;
  logic [2:0]  sel_c;

  logic [127:0] in_data_a;
  logic [95:0]  in_data_b;
  logic [79:0]  in_data_c;

  logic [31:0] out_data_a, out_data_b;
  logic [15:0] out_data_c;
  logic        out_valid_a, out_valid_b, out_valid_c;
  logic        out_err_a, out_err_b, out_err_c;

  int checks = 0;
  int failures = 0;

  always_comb begin
    in_data_a = '0;
    for (int k = 0; k < 4; k++) in_data_a[k*32 +: 32] = lane_a[k];
  end
  always_comb begin
    in_data_b = '0;
    for (int k = 0; k < 3; k++) in_data_b[k*32 +: 32] = lane_b[k];
  end
  always_comb begin
    in_data_c = '0;
    for (int k = 0; k < 5; k++) in_data_c[k*16 +: 16] = lane_c[k];
  end

  pipe_mux_reg #(.WIDTH(32), .N(4), .PIPE_STAGES(1), .RST_VAL(32'h0)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data_a), .in_sel(sel_a), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(out_data_a), .out_valid(out_valid_a),
    .out_sel_err(out_err_a));

  pipe_mux_reg #(.WIDTH(32), .N(3), .PIPE_STAGES(1), .RST_VAL(32'h0)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_sel(sel_b), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_sel_err(out_err_b));

  pipe_mux_reg #(.WIDTH(16), .N(5), .PIPE_STAGES(2), .RST_VAL(16'hA5A5)) dut_c (
    .clk(clk), .rst(rst), .in_data(in_data_c), .in_sel(sel_c), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(out_data_c), .out_valid(out_valid_c),
    .out_sel_err(out_err_c));

  // Reference model: per instance, a list of pipeline slots (oldest last).
  int          n_of    [3] = '{4, 3, 5};
  int          ps_of   [3] = '{1, 1, 2};
  logic [31:0] rstv_of [3] = '{32'h0, 32'h0, 32'h0000A5A5};
  logic        m_vld  [3][2];
  logic        m_err  [3][2];
  logic [31:0] m_data [3][2];

  // What the select rule produces for instance d: {err, data}.
  function automatic logic [32:0] pick(input int d);
    int idx;
    logic [31:0] v;
    case (d)
      0:       idx = int'(sel_a);
      1:       idx = int'(sel_b);
      default: idx = int'(sel_c);
    endcase
    if (idx >= n_of[d]) return {1'b1, 32'h0};
    case (d)
      0:       v = lane_a[idx];
      1:       v = lane_b[idx];
      default: v = {16'h0, lane_c[idx]};
    endcase
    return {1'b0, v};
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 3; d++)
      for (int s = 0; s < 2; s++) begin
        m_vld[d][s]  = 1'b0;
        m_err[d][s]  = 1'b0;
        m_data[d][s] = rstv_of[d];
      end
  endtask

  task automatic model_edge();
    logic [32:0] p;
    if (rst || flush) begin
      model_clear();
    end else if (!stall) begin
      for (int d = 0; d < 3; d++) begin
        for (int s = ps_of[d] - 1; s >= 1; s--) begin
          m_vld[d][s] = m_vld[d][s-1];
          if (m_vld[d][s-1]) begin
            m_err[d][s]  = m_err[d][s-1];
            m_data[d][s] = m_data[d][s-1];
          end
        end
        m_vld[d][0] = in_valid;
        if (in_valid) begin
          p = pick(d);
          m_err[d][0]  = p[32];
          m_data[d][0] = p[31:0];
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic        ov, oe, ev, ee;
    logic [31:0] od, ed;
    int          last;
    for (int d = 0; d < 3; d++) begin
      last = ps_of[d] - 1;
      ev = m_vld[d][last];
      ee = m_err[d][last] & ev;
      ed = m_data[d][last];
      case (d)
        0:       begin ov = out_valid_a; oe = out_err_a; od = out_data_a; end
        1:       begin ov = out_valid_b; oe = out_err_b; od = out_data_b; end
        default: begin ov = out_valid_c; oe = out_err_c; od = {16'h0, out_data_c}; end
      endcase
      checks++;
      assert (ov === ev) else begin
        failures++;
        $error("FAIL %s valid dut%0d observed=%0b expected=%0b", tag, d, ov, ev);
      end
      checks++;
      assert (oe === ee) else begin
        failures++;
        $error("FAIL %s err dut%0d observed=%0b expected=%0b", tag, d, oe, ee);
      end
      checks++;
      assert (od === ed) else begin
        failures++;
        $error("FAIL %s data dut%0d observed=%h expected=%h", tag, d, od, ed);
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Reset pulse strictly between edges; outputs must clear before next edge.
  task automatic async_reset(input string tag);
    #1 rst = 1'b1;
    #1;
    model_clear();
    check_all(tag);
    check_val({tag, "_c_valid"}, {31'h0, out_valid_c}, 32'h0);
    check_val({tag, "_c_data"}, {16'h0, out_data_c}, 32'h0000A5A5);
    #1 rst = 1'b0;
  endtask

  task automatic set_lanes(input int base);
    for (int k = 0; k < 4; k++) lane_a[k] = 32'((k + 1) * 32'h11 + base);
    for (int k = 0; k < 3; k++) lane_b[k] = 32'(32'h100 + k + base);
    for (int k = 0; k < 5; k++) lane_c[k] = 16'(16'h200 + k + base);
  endtask

  task automatic set_sel(input int s);
    sel_a = 2'(s);
    sel_b = 2'(s);
    sel_c = 3'(s);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    set_lanes(0);
    set_sel(0);
    model_clear();
    #1 rst = 1'b1;
    #1;
    check_all("reset");
    tick("reset_hold");
    #1 rst = 1'b0;
    tick("idle");

    // Lane walk: 0x11..0x44 on consecutive cycles.
    async_reset("rst_between_edges");
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_sel(i);
      tick("walk");
      check_val("walk_a_data", out_data_a, 32'((i + 1) * 32'h11));
      check_val("walk_a_valid", {31'h0, out_valid_a}, 32'h1);
    end

    // Out-of-range select on N=3 then back in range.
    sel_b = 2'd3;
    tick("sel_err");
    check_val("sel_err_b", {31'h0, out_err_b}, 32'h1);
    check_val("sel_err_b_data", out_data_b, 32'h0);
    sel_b = 2'd1;
    tick("sel_ok");
    check_val("sel_ok_b", {31'h0, out_err_b}, 32'h0);
    check_val("sel_ok_b_data", out_data_b, 32'h101);
    sel_c = 3'd6;
    tick("sel_err_c");
    sel_c = 3'd2;
    tick("sel_ok_c");

    // Two-cycle stall mid-stream.
    for (int i = 0; i < 6; i++) begin
      set_lanes(i * 3);
      set_sel(i % 3);
      stall = (i == 2 || i == 3);
      tick("stall");
    end
    stall = 1'b0;
    in_valid = 1'b0;
    tick("drain");
    tick("drain");

    // Flush and stall together with both stages full.
    in_valid = 1'b1;
    set_sel(1);
    tick("fill");
    set_sel(2);
    tick("fill");
    flush = 1'b1; stall = 1'b1;
    tick("flush_stall");
    check_val("flush_c_valid", {31'h0, out_valid_c}, 32'h0);
    check_val("flush_c_data", {16'h0, out_data_c}, 32'h0000A5A5);
    flush = 1'b0; stall = 1'b0;
    set_sel(4);
    tick("post_flush");
    in_valid = 1'b0;
    tick("post_flush");
    check_val("post_flush_c", {16'h0, out_data_c}, {16'h0, lane_c[4]});
    tick("post_flush");

    // Reset while stalled with work in flight.
    in_valid = 1'b1;
    tick("pre_rst");
    tick("pre_rst");
    stall = 1'b1;
    tick("pre_rst_stall");
    async_reset("rst_mid_stall");
    stall = 1'b0;
    set_sel(3);
    tick("after_rst");
    in_valid = 1'b0;
    tick("after_rst");
    tick("after_rst");

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 4; k++) lane_a[k] = $urandom();
      for (int k = 0; k < 3; k++) lane_b[k] = $urandom();
      for (int k = 0; k < 5; k++) lane_c[k] = 16'($urandom());
      sel_a    = 2'($urandom_range(0, 3));
      sel_b    = 2'($urandom_range(0, 3));
      sel_c    = 3'($urandom_range(0, 7));
      in_valid = ($urandom_range(0, 9) < 7);
      stall    = ($urandom_range(0, 99) < 15);
      flush    = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 99) < 2) async_reset("rand_rst");
      tick("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
